// File: rtl/hazard_sched_if.sv
// hazard_sched_if: pipeline-register fields consumed by the hazard scheduler
// and the stall/forward controls it returns. master = pipeline side, slave =
// scheduler side.
interface hazard_sched_if;
   // D stage
   logic [4:0]  rs_d, rt_d;
   logic [1:0]  tuse_rs_d, tuse_rt_d;
   logic        md_use_d;
   // E/M/W pipeline register fields
   logic [4:0]  rs_e, rt_e;
   logic [4:0]  a3_e, a3_m, a3_w;
   logic        we_e, we_m, we_w;
   logic [1:0]  tnew_e, tnew_m;
   logic [4:0]  rt_m;
   logic        md_start_e, md_div_e;
   // controls back to the pipeline
   logic        stall_fd, clr_de;
   logic [1:0]  fwd_rs_d, fwd_rt_d;
   logic [1:0]  fwd_rs_e, fwd_rt_e;
   logic        fwd_rt_m;
   logic        md_busy;
   logic [31:0] stall_cnt;

   modport master (
      output rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
             rs_e, rt_e, a3_e, a3_m, a3_w, we_e, we_m, we_w,
             tnew_e, tnew_m, rt_m, md_start_e, md_div_e,
      input  stall_fd, clr_de, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
             fwd_rt_m, md_busy, stall_cnt
   );

   modport slave (
      input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
             rs_e, rt_e, a3_e, a3_m, a3_w, we_e, we_m, we_w,
             tnew_e, tnew_m, rt_m, md_start_e, md_div_e,
      output stall_fd, clr_de, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
             fwd_rt_m, md_busy, stall_cnt
   );
endinterface

// File: rtl/hazard_sched.sv
// hazard_sched: Tuse/Tnew hazard scheduler for the five-stage MIPS pipeline.
// Produces F/D stall, D/E bubble, and D/E/M forwarding selects, and tracks
// the multi-cycle MDU busy window.
// Optional feature macro: HAZARD_STALL_CNT_EN enables the stall-cycle
// counter; when undefined stall_cnt reads 0.
module hazard_sched #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input logic           clk,
   input logic           reset,
   hazard_sched_if.slave hz
);

   localparam logic [3:0] MULT_N = 4'(MULT_CYC);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

   // A stage matches a source when it writes a nonzero register equal to it.
   function automatic logic hit(input logic we, input logic [4:0] a3,
                                input logic [4:0] r);
      return we && (a3 != 5'd0) && (a3 == r);
   endfunction

   // Youngest-match D-stage select; a match that is not ready yet yields 0
   // and the stall holds the instruction until it is.
   function automatic logic [1:0] sel_d(input logic e_hit, input logic m_hit,
                                        input logic w_hit,
                                        input logic [1:0] tnew_e,
                                        input logic [1:0] tnew_m);
      if (e_hit)      return (tnew_e == 2'd0) ? 2'd1 : 2'd0;
      else if (m_hit) return (tnew_m == 2'd0) ? 2'd2 : 2'd0;
      else if (w_hit) return 2'd3;
      else            return 2'd0;
   endfunction

   logic       e_rs_d, m_rs_d, w_rs_d;
   logic       e_rt_d, m_rt_d, w_rt_d;
   logic       m_rs_e, w_rs_e, m_rt_e, w_rt_e;
   logic       stall_rs, stall_rt, stall_md, stall;
   logic [3:0] cnt;
   logic       busy;

   // Per-stage source matches.
   always_comb begin
      e_rs_d = hit(hz.we_e, hz.a3_e, hz.rs_d);
      m_rs_d = hit(hz.we_m, hz.a3_m, hz.rs_d);
      w_rs_d = hit(hz.we_w, hz.a3_w, hz.rs_d);
      e_rt_d = hit(hz.we_e, hz.a3_e, hz.rt_d);
      m_rt_d = hit(hz.we_m, hz.a3_m, hz.rt_d);
      w_rt_d = hit(hz.we_w, hz.a3_w, hz.rt_d);
      m_rs_e = hit(hz.we_m, hz.a3_m, hz.rs_e);
      w_rs_e = hit(hz.we_w, hz.a3_w, hz.rs_e);
      m_rt_e = hit(hz.we_m, hz.a3_m, hz.rt_e);
      w_rt_e = hit(hz.we_w, hz.a3_w, hz.rt_e);
   end

   // Stall when a producer in E or M cannot deliver before the consumer needs
   // it, or when an MDU instruction meets a busy MDU. W never stalls.
   always_comb begin
      stall_rs = (e_rs_d && (hz.tnew_e > hz.tuse_rs_d)) ||
                 (m_rs_d && (hz.tnew_m > hz.tuse_rs_d));
      stall_rt = (e_rt_d && (hz.tnew_e > hz.tuse_rt_d)) ||
                 (m_rt_d && (hz.tnew_m > hz.tuse_rt_d));
      stall_md = hz.md_use_d && busy;
      stall    = stall_rs || stall_rt || stall_md;
   end

   // Forwarding selects for D, E and M consumers.
   always_comb begin
      hz.fwd_rs_d = sel_d(e_rs_d, m_rs_d, w_rs_d, hz.tnew_e, hz.tnew_m);
      hz.fwd_rt_d = sel_d(e_rt_d, m_rt_d, w_rt_d, hz.tnew_e, hz.tnew_m);
      if (m_rs_e && (hz.tnew_m == 2'd0)) hz.fwd_rs_e = 2'd1;
      else if (w_rs_e)                   hz.fwd_rs_e = 2'd2;
      else                               hz.fwd_rs_e = 2'd0;
      if (m_rt_e && (hz.tnew_m == 2'd0)) hz.fwd_rt_e = 2'd1;
      else if (w_rt_e)                   hz.fwd_rt_e = 2'd2;
      else                               hz.fwd_rt_e = 2'd0;
      hz.fwd_rt_m = hit(hz.we_w, hz.a3_w, hz.rt_m);
   end

   // MDU busy counter: a start (re)loads, otherwise count down to 0 and hold.
   always_ff @(posedge clk) begin
      if (reset)              cnt <= 4'd0;
      else if (hz.md_start_e) cnt <= hz.md_div_e ? DIV_N : MULT_N;
      else if (cnt != 4'd0)   cnt <= cnt - 4'd1;
   end

   // The start cycle itself already counts as busy.
   always_comb busy = hz.md_start_e || (cnt != 4'd0);

   // Drive the remaining controls.
   always_comb begin
      hz.stall_fd = stall;
      hz.clr_de   = stall;
      hz.md_busy  = busy;
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] scnt;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (reset)                              scnt <= 32'd0;
      else if (stall && (scnt != 32'hFFFF_FFFF)) scnt <= scnt + 32'd1;
   end

   // Expose the counter.
   always_comb hz.stall_cnt = scnt;
`else
   // Counter not built.
   always_comb hz.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed vectors for hazard_sched, checked every cycle
// against a rule-level model plus literal expectations from the test plan.
module tb_hazard_sched;
   logic clk = 1'b0;
   logic reset;
   hazard_sched_if bus();

   hazard_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (bus)
   );

   always #5 clk = ~clk;

   int     nvec = 0;
   int     nerr = 0;
   bit     chk_en = 0;
   int     cyc = 0;
   int     last_busy = -1;
   longint scnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---- model: stages as a list, youngest first (E, M, W) ----
   function automatic bit stage_hit(input int s, input logic [4:0] r);
      logic we; logic [4:0] a3;
      case (s)
         0: begin we = bus.we_e; a3 = bus.a3_e; end
         1: begin we = bus.we_m; a3 = bus.a3_m; end
         default: begin we = bus.we_w; a3 = bus.a3_w; end
      endcase
      return (we === 1'b1) && (a3 != 0) && (a3 == r);
   endfunction

   function automatic int stage_tnew(input int s);
      case (s)
         0: return int'(bus.tnew_e);
         1: return int'(bus.tnew_m);
         default: return 0;
      endcase
   endfunction

   function automatic int m_fwd_d(input logic [4:0] r);
      for (int s = 0; s < 3; s++)
         if (stage_hit(s, r)) return (stage_tnew(s) == 0) ? s + 1 : 0;
      return 0;
   endfunction

   function automatic int m_fwd_e(input logic [4:0] r);
      if (stage_hit(1, r) && stage_tnew(1) == 0) return 1;
      if (stage_hit(2, r)) return 2;
      return 0;
   endfunction

   function automatic bit m_busy();
      return bus.md_start_e || (cyc <= last_busy);
   endfunction

   function automatic bit m_stall();
      bit st = 0;
      for (int s = 0; s < 2; s++) begin
         if (stage_hit(s, bus.rs_d) && stage_tnew(s) > int'(bus.tuse_rs_d)) st = 1;
         if (stage_hit(s, bus.rt_d) && stage_tnew(s) > int'(bus.tuse_rt_d)) st = 1;
      end
      if (bus.md_use_d && m_busy()) st = 1;
      return st;
   endfunction

   function automatic logic [31:0] m_scnt();
`ifdef HAZARD_STALL_CNT_EN
      return (scnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : scnt[31:0];
`else
      return 32'd0;
`endif
   endfunction

   // Model state advance at each edge (inputs change only after the edge).
   always @(posedge clk) begin
      if (reset) begin
         last_busy <= -1;
         scnt      <= 0;
      end else begin
         if (bus.md_start_e) last_busy <= cyc + (bus.md_div_e ? 10 : 5);
         if (m_stall()) scnt <= scnt + 1;
      end
      cyc <= cyc + 1;
   end

   // Compare every output against the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall_fd", 32'(bus.stall_fd), 32'(m_stall()));
         chk("clr_de",   32'(bus.clr_de),   32'(m_stall()));
         chk("fwd_rs_d", 32'(bus.fwd_rs_d), 32'(m_fwd_d(bus.rs_d)));
         chk("fwd_rt_d", 32'(bus.fwd_rt_d), 32'(m_fwd_d(bus.rt_d)));
         chk("fwd_rs_e", 32'(bus.fwd_rs_e), 32'(m_fwd_e(bus.rs_e)));
         chk("fwd_rt_e", 32'(bus.fwd_rt_e), 32'(m_fwd_e(bus.rt_e)));
         chk("fwd_rt_m", 32'(bus.fwd_rt_m), 32'(stage_hit(2, bus.rt_m)));
         chk("md_busy",  32'(bus.md_busy),  32'(m_busy()));
         chk("stall_cnt", bus.stall_cnt,    m_scnt());
      end
   end

   task automatic idle();
      bus.rs_d = 0; bus.rt_d = 0; bus.tuse_rs_d = 3; bus.tuse_rt_d = 3;
      bus.md_use_d = 0; bus.rs_e = 0; bus.rt_e = 0;
      bus.a3_e = 0; bus.a3_m = 0; bus.a3_w = 0;
      bus.we_e = 0; bus.we_m = 0; bus.we_w = 0;
      bus.tnew_e = 0; bus.tnew_m = 0; bus.rt_m = 0;
      bus.md_start_e = 0; bus.md_div_e = 0;
   endtask

   // Advance to just after the next edge, where new inputs are applied.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Let combinational outputs settle before a literal check.
   task automatic settle();
      #3;
   endtask

`ifdef HAZARD_STALL_CNT_EN
   localparam logic [31:0] EXP13 = 32'd13;
`else
   localparam logic [31:0] EXP13 = 32'd0;
`endif

   initial begin
      idle();
      reset = 1'b1;
      tick(); chk_en = 1; settle();
      chk("rst stall_fd", 32'(bus.stall_fd), 0);
      chk("rst md_busy",  32'(bus.md_busy), 0);
      chk("rst stall_cnt", bus.stall_cnt, 0);
      chk("rst fwd_rs_d", 32'(bus.fwd_rs_d), 0);
      tick(); reset = 1'b0;

      // Load-use into a branch (Tuse 0): two stall cycles, then W forward.
      tick(); idle();
      bus.rs_d = 1; bus.rt_d = 1; bus.tuse_rs_d = 0; bus.tuse_rt_d = 0;
      bus.a3_e = 1; bus.we_e = 1; bus.tnew_e = 2;
      settle();
      chk("lu1 stall_fd", 32'(bus.stall_fd), 1);
      chk("lu1 clr_de",   32'(bus.clr_de), 1);
      tick(); bus.a3_e = 0; bus.we_e = 0; bus.tnew_e = 0;
      bus.a3_m = 1; bus.we_m = 1; bus.tnew_m = 1;
      settle();
      chk("lu2 stall_fd", 32'(bus.stall_fd), 1);
      chk("lu2 fwd_rs_d", 32'(bus.fwd_rs_d), 0);
      tick(); bus.a3_m = 0; bus.we_m = 0; bus.tnew_m = 0;
      bus.a3_w = 1; bus.we_w = 1;
      settle();
      chk("lu3 stall_fd", 32'(bus.stall_fd), 0);
      chk("lu3 fwd_rs_d", 32'(bus.fwd_rs_d), 3);

      // Ready ALU result in E; then same register in E, M and W.
      tick(); idle();
      bus.rs_d = 3; bus.tuse_rs_d = 0; bus.a3_e = 3; bus.we_e = 1;
      settle();
      chk("alu fwd_rs_d", 32'(bus.fwd_rs_d), 1);
      tick(); bus.a3_m = 3; bus.we_m = 1; bus.a3_w = 3; bus.we_w = 1;
      settle();
      chk("ewin fwd_rs_d", 32'(bus.fwd_rs_d), 1);
      chk("ewin stall_fd", 32'(bus.stall_fd), 0);

      // Ready M-stage producer in D: select 2.
      tick(); idle();
      bus.rt_d = 9; bus.tuse_rt_d = 1; bus.a3_m = 9; bus.we_m = 1;
      bus.a3_w = 9; bus.we_w = 1;

      // E and M consumers.
      tick(); idle();
      bus.rs_e = 3; bus.rt_e = 5; bus.rt_m = 5;
      bus.a3_m = 3; bus.we_m = 1; bus.a3_w = 5; bus.we_w = 1;
      settle();
      chk("e fwd_rs_e", 32'(bus.fwd_rs_e), 1);
      chk("e fwd_rt_e", 32'(bus.fwd_rt_e), 2);
      chk("m fwd_rt_m", 32'(bus.fwd_rt_m), 1);
      tick(); bus.rt_e = 3; bus.tnew_m = 1; bus.a3_w = 3; bus.rt_m = 6;

      // Register 0 and unused operands never stall or forward.
      tick(); idle();
      bus.rs_d = 0; bus.tuse_rs_d = 0; bus.a3_e = 0; bus.we_e = 1; bus.tnew_e = 2;
      bus.a3_w = 0; bus.we_w = 1;
      settle();
      chk("r0 stall_fd", 32'(bus.stall_fd), 0);
      chk("r0 fwd_rs_d", 32'(bus.fwd_rs_d), 0);
      tick(); idle();
      bus.rs_d = 7; bus.tuse_rs_d = 3; bus.a3_e = 7; bus.we_e = 1; bus.tnew_e = 2;

      // Divide with a waiting MDU consumer: 11 stalled cycles.
      tick(); idle();
      bus.md_start_e = 1; bus.md_div_e = 1; bus.md_use_d = 1;
      settle();
      chk("div t busy", 32'(bus.md_busy), 1);
      for (int i = 1; i <= 11; i++) begin
         tick(); bus.md_start_e = 0; bus.md_div_e = 0;
         settle();
         if (i == 10) chk("div last stall", 32'(bus.stall_fd), 1);
         if (i == 11) chk("div release", 32'(bus.stall_fd), 0);
      end
      tick(); idle(); settle();
      chk("stall_cnt 13", bus.stall_cnt, EXP13);

      // Multiply: 6 stalled cycles.
      tick(); bus.md_start_e = 1; bus.md_use_d = 1;
      for (int i = 1; i <= 6; i++) begin
         tick(); bus.md_start_e = 0;
         settle();
         if (i == 5) chk("mul last stall", 32'(bus.stall_fd), 1);
         if (i == 6) chk("mul release", 32'(bus.stall_fd), 0);
      end

      // Start while busy reloads the counter.
      tick(); idle(); bus.md_start_e = 1; bus.md_div_e = 1;
      tick(); bus.md_start_e = 0; bus.md_div_e = 0;
      tick(); bus.md_start_e = 1;
      for (int i = 0; i < 8; i++) begin
         tick(); bus.md_start_e = 0;
      end

      // Reset three cycles into a divide.
      tick(); idle(); bus.md_start_e = 1; bus.md_div_e = 1; bus.md_use_d = 1;
      tick(); bus.md_start_e = 0; bus.md_div_e = 0;
      tick();
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      settle();
      chk("rstmid md_busy",  32'(bus.md_busy), 0);
      chk("rstmid stall_fd", 32'(bus.stall_fd), 0);
      chk("rstmid stall_cnt", bus.stall_cnt, 0);

      tick(); idle();
      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
